// File: rtl/mdl_scomdev_oob.sv
// Device-side SATA OOB sequencer: COMRESET -> COMINIT bursts -> host COMWAKE -> COMWAKE bursts -> ACTIVE.
// Optional macro SCOMDEV_WAKE_RETRY_EN: WAIT_WAKE resends COMINIT after WAKE_TIMEOUT cycles without COMWAKE.
module mdl_scomdev_oob #(
  parameter int          NUM_COMINIT   = 3,
  parameter int          NUM_COMWAKE   = 6,
  parameter int          NUM_SUBBURST  = 4,
  parameter logic [39:0] COM_SEQ       = 40'b0011001100_1100110011_0011001100_1100110011,
  parameter int          COMINIT_IDLES = 480,
  parameter int          COMWAKE_IDLES = 160,
  parameter int          SYNC_STAGES   = 3,
  parameter int          WAKE_TIMEOUT  = 65536
) (
  input  logic       i_txclk,
  input  logic       i_reset,
  input  logic       i_comreset,
  input  logic       i_comwake,
  input  logic       i_tx,
  output logic       o_reset,
  output logic       o_tx,
  output logic       o_idle,
  output logic [2:0] o_state
);

  localparam int GAP_MAX = (COMINIT_IDLES > COMWAKE_IDLES) ? COMINIT_IDLES : COMWAKE_IDLES;
  localparam int BUR_MAX = (NUM_COMINIT > NUM_COMWAKE) ? NUM_COMINIT : NUM_COMWAKE;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam int BW      = $clog2(BUR_MAX + 1);
  localparam int SW      = $clog2(NUM_SUBBURST + 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(NUM_SUBBURST - 1);

  typedef enum logic [2:0] {
    CLEAR_RESET = 3'd0,
    SEND_INIT   = 3'd1,
    WAIT_WAKE   = 3'd2,
    SEND_WAKE   = 3'd3,
    ACTIVE      = 3'd4
  } state_t;

  if (SYNC_STAGES < 2 || NUM_SUBBURST < 1 || COMINIT_IDLES < 1 ||
      COMWAKE_IDLES < 1 || WAKE_TIMEOUT < 1) begin : g_bad_params
    $error("mdl_scomdev_oob: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] comreset_sync_q, comwake_sync_q;
  logic                   ck_comreset, ck_comwake;
  state_t                 state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d, gap_last;
  logic [SW-1:0]          sub_q, sub_d;
  logic [5:0]             sym_q, sym_d;
  logic [BW-1:0]          burst_q, burst_d, burst_last;
  logic                   in_burst_q, in_burst_d;
  logic [39:0]            shift_q, shift_d;
  logic                   tx_q, tx_d, idle_q, idle_d, link_rst_q, link_rst_d;
  logic                   reload;
`ifdef SCOMDEV_WAKE_RETRY_EN
  localparam int TW = $clog2(WAKE_TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
`endif

  always_ff @(posedge i_txclk or posedge i_reset) begin
    if (i_reset) begin
      comreset_sync_q <= '0;
      comwake_sync_q  <= '0;
    end else begin
      comreset_sync_q <= {comreset_sync_q[SYNC_STAGES-2:0], i_comreset};
      comwake_sync_q  <= {comwake_sync_q[SYNC_STAGES-2:0], i_comwake};
    end
  end

  assign ck_comreset = comreset_sync_q[SYNC_STAGES-1];
  assign ck_comwake  = comwake_sync_q[SYNC_STAGES-1];

  // Gap and burst limits follow whichever sequence (COMINIT or COMWAKE) is running.
  assign gap_last   = (state_q == SEND_INIT) ? GW'(COMINIT_IDLES - 1) : GW'(COMWAKE_IDLES - 1);
  assign burst_last = (state_q == SEND_INIT) ? BW'(NUM_COMINIT - 1) : BW'(NUM_COMWAKE - 1);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    sub_d      = sub_q;
    sym_d      = sym_q;
    burst_d    = burst_q;
    in_burst_d = in_burst_q;
    shift_d    = shift_q;
    reload     = 1'b0;
`ifdef SCOMDEV_WAKE_RETRY_EN
    wait_d     = '0;
`endif
    case (state_q)
      CLEAR_RESET: begin
        reload  = 1'b1;
        state_d = SEND_INIT;
      end
      SEND_INIT, SEND_WAKE: begin
        if (state_q == SEND_WAKE && ck_comwake) begin
          reload = 1'b1;
        end else if (!in_burst_q) begin
          if (gap_q == gap_last) begin
            in_burst_d = 1'b1;
            sub_d      = '0;
            sym_d      = '0;
            shift_d    = COM_SEQ;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end else if (sym_q != 6'd39) begin
          sym_d   = sym_q + 6'd1;
          shift_d = {shift_q[38:0], 1'b0};
        end else if (sub_q != SUB_LAST) begin
          sym_d   = '0;
          sub_d   = sub_q + SW'(1);
          shift_d = COM_SEQ;
        end else if (burst_q != burst_last) begin
          burst_d    = burst_q + BW'(1);
          in_burst_d = 1'b0;
          gap_d      = '0;
        end else begin
          reload  = 1'b1;
          state_d = (state_q == SEND_INIT) ? WAIT_WAKE : ACTIVE;
        end
      end
      WAIT_WAKE: begin
        reload = 1'b1;
        if (ck_comwake) begin
          state_d = SEND_WAKE;
`ifdef SCOMDEV_WAKE_RETRY_EN
        end else if (wait_q == TW'(WAKE_TIMEOUT - 1)) begin
          state_d = SEND_INIT;
        end else begin
          wait_d = wait_q + TW'(1);
`endif
        end
      end
      ACTIVE: state_d = ACTIVE;
      default: begin
        reload  = 1'b1;
        state_d = CLEAR_RESET;
      end
    endcase

    if (ck_comreset) begin
      state_d = CLEAR_RESET;
      reload  = 1'b1;
    end

    if (reload) begin
      gap_d      = '0;
      sub_d      = '0;
      sym_d      = '0;
      burst_d    = '0;
      in_burst_d = 1'b0;
      shift_d    = COM_SEQ;
    end

    // Outputs are derived from next-cycle values so they register in step with the state.
    idle_d     = 1'b1;
    tx_d       = 1'b0;
    link_rst_d = 1'b1;
    if (state_d == ACTIVE) begin
      idle_d     = 1'b0;
      tx_d       = i_tx;
      link_rst_d = 1'b0;
    end else if ((state_d == SEND_INIT || state_d == SEND_WAKE) && in_burst_d) begin
      idle_d = 1'b0;
      tx_d   = shift_d[39];
    end
  end

  always_ff @(posedge i_txclk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= CLEAR_RESET;
      gap_q      <= '0;
      sub_q      <= '0;
      sym_q      <= '0;
      burst_q    <= '0;
      in_burst_q <= 1'b0;
      shift_q    <= COM_SEQ;
      tx_q       <= 1'b0;
      idle_q     <= 1'b1;
      link_rst_q <= 1'b1;
`ifdef SCOMDEV_WAKE_RETRY_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      sub_q      <= sub_d;
      sym_q      <= sym_d;
      burst_q    <= burst_d;
      in_burst_q <= in_burst_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      idle_q     <= idle_d;
      link_rst_q <= link_rst_d;
`ifdef SCOMDEV_WAKE_RETRY_EN
      wait_q     <= wait_d;
`endif
    end
  end

  assign o_state = state_q;
  assign o_tx    = tx_q;
  assign o_idle  = idle_q;
  assign o_reset = link_rst_q;

endmodule

// File: tb/tb_mdl_scomdev_oob.sv
// Bench for mdl_scomdev_oob: expected per-cycle streams of {state, reset, idle, tx} built from the OOB rules.
module tb_mdl_scomdev_oob;
  localparam int          S   = 3;
  localparam int          GI  = 480;
  localparam int          GK  = 160;
  localparam int          BL  = 160;
  localparam logic [39:0] SEQ = 40'b0011001100_1100110011_0011001100_1100110011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       comreset = 1'b0;
  logic       comwake = 1'b0;
  logic       tx_in = 1'b0;
  logic       o_reset, o_tx, o_idle;
  logic [2:0] o_state;

  int checks = 0;
  int failures = 0;
  int wake_left = 0;
  int creset_left = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic tx;
    logic wake;
    logic exp_tx;
  } vec_t;
  vec_t vecs[10];

  mdl_scomdev_oob #(.SYNC_STAGES(S), .WAKE_TIMEOUT(1000)) dut (
    .i_txclk(clk), .i_reset(rst), .i_comreset(comreset), .i_comwake(comwake), .i_tx(tx_in),
    .o_reset(o_reset), .o_tx(o_tx), .o_idle(o_idle), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Advance to the next sample point; timed input pulses are released here.
  task automatic cyc();
    @(negedge clk);
    if (wake_left > 0) begin
      wake_left--;
      if (wake_left == 0) comwake = 1'b0;
    end
    if (creset_left > 0) begin
      creset_left--;
      if (creset_left == 0) comreset = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_idle(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({st, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic push_bits(input logic [2:0] st, input int from, input int to);
    for (int j = from; j < to; j++) exp_q.push_back({st, 1'b1, 1'b0, SEQ[39 - (j % 40)]});
  endtask

  task automatic push_seq(input logic [2:0] st, input int gap, input int nb);
    for (int b = 0; b < nb; b++) begin
      push_idle(st, gap);
      push_bits(st, 0, BL);
    end
  endtask

  task automatic push_init();
    push_seq(3'd1, GI, 3);
    push_idle(3'd2, 1);
  endtask

  task automatic run_stream(input string name);
    int idx;
    int errs;
    logic [5:0] e;
    logic [5:0] a;
    idx = 0;
    errs = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc();
      a = {o_state, o_reset, o_idle, o_tx};
      checks++;
      if (a !== e) begin
        failures++;
        errs++;
        if (errs <= 4)
          $display("FAIL %s[%0d]: got state=%0d reset=%b idle=%b tx=%b expected state=%0d reset=%b idle=%b tx=%b",
                   name, idx, a[5:3], a[2], a[1], a[0], e[5:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic comreset_to_wait(input int len);
    comreset = 1'b1;
    creset_left = len;
    exp_q.push_back({3'd4, 1'b0, 1'b0, tx_in});
    for (int i = 1; i < S; i++) exp_q.push_back({3'd4, 1'b0, 1'b0, 1'b0});
    push_idle(3'd0, len);
    push_init();
  endtask

  initial begin
    logic [6:0] lfsr;
    logic       bit_v;
    int w, h1, h2, bb, m;

    vecs[0] = '{1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b0};

    #2 rst = 1'b1;
    repeat (3) cyc();
    chk("reset_state", int'(o_state), 0);
    chk("reset_oreset", int'(o_reset), 1);
    chk("reset_idle", int'(o_idle), 1);
    chk("reset_tx", int'(o_tx), 0);
    rst = 1'b0;

    push_idle(3'd1, 2);
    run_stream("boot");

    comreset = 1'b1;
    creset_left = 10;
    push_idle(3'd1, S);
    push_idle(3'd0, 10);
    push_init();
    run_stream("comreset_init");

`ifdef SCOMDEV_WAKE_RETRY_EN
    push_idle(3'd2, 999);
    push_init();
    run_stream("wake_retry");
`endif

    w = $urandom_range(0, 30);
    push_idle(3'd2, w);
    run_stream("wait_wake");

    comwake = 1'b1;
    wake_left = 300;
    push_idle(3'd2, S);
    push_idle(3'd3, 299);
    push_seq(3'd3, GK, 6);
    exp_q.push_back({3'd4, 1'b0, 1'b0, 1'b0});
    run_stream("comwake_seq");

    for (int i = 0; i < 10; i++) begin
      tx_in = vecs[i].tx;
      comwake = vecs[i].wake;
      cyc();
      chk($sformatf("vec%0d_tx", i), int'(o_tx), int'(vecs[i].exp_tx));
      chk($sformatf("vec%0d_link", i), int'({o_state, o_reset, o_idle}), int'({3'd4, 1'b0, 1'b0}));
    end

    lfsr = 7'($urandom_range(1, 127));
    for (int i = 0; i < 150; i++) begin
      bit_v = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], bit_v};
      tx_in = bit_v;
      comwake = 1'($urandom_range(0, 1));
      cyc();
      chk("prbs_active", int'({o_state, o_reset, o_idle, o_tx}), int'({3'd4, 1'b0, 1'b0, bit_v}));
    end
    comwake = 1'b0;
    tx_in = 1'b0;

    comreset_to_wait(6);
    run_stream("active_comreset");

    h1 = $urandom_range(1, 80);
    bb = $urandom_range(0, 5);
    m = $urandom_range(10, 140);
    comwake = 1'b1;
    wake_left = h1;
    push_idle(3'd2, S);
    push_idle(3'd3, h1 - 1);
    push_seq(3'd3, GK, bb);
    push_idle(3'd3, GK);
    push_bits(3'd3, 0, m + 1);
    run_stream("wake_pre_abort");

    h2 = $urandom_range(1, 50);
    comwake = 1'b1;
    wake_left = h2;
    push_bits(3'd3, m + 1, m + 1 + S);
    push_idle(3'd3, h2 - 1);
    push_seq(3'd3, GK, 6);
    exp_q.push_back({3'd4, 1'b0, 1'b0, 1'b0});
    run_stream("wake_abort_restart");

    comreset_to_wait(4);
    run_stream("active_comreset2");

    h1 = $urandom_range(1, 100);
    comwake = 1'b1;
    wake_left = h1;
    push_idle(3'd2, S);
    push_idle(3'd3, h1 - 1);
    push_seq(3'd3, GK, 3);
    push_idle(3'd3, GK);
    push_bits(3'd3, 0, 71);
    run_stream("wake_to_bit70");

    comreset = 1'b1;
    creset_left = 10;
    push_bits(3'd3, 71, 71 + S);
    push_idle(3'd0, 10);
    push_init();
    run_stream("midburst_comreset");

    #2 rst = 1'b1;
    #1;
    chk("async_reset_state", int'(o_state), 0);
    chk("async_reset_oreset", int'(o_reset), 1);
    chk("async_reset_idle", int'(o_idle), 1);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
